// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the pipeline controller: FSM states, trap cause codes
// and the default trap vector.
package pipeline_ctrl_pkg;

    typedef enum logic [2:0] {
        StRun          = 3'd0,
        StTrapFlush    = 3'd1,
        StTrapRedirect = 3'd2,
        StHalt         = 3'd3
    } state_t;

    typedef enum logic [1:0] {
        CauseNone = 2'd0,
        CauseOvf  = 2'd1,
        CauseExt  = 2'd2
    } cause_t;

    localparam logic [31:0] DefaultTrapVector = 32'd2000;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use detector: EX load whose non-zero destination feeds
// a source register actually read by the ID instruction.
module hazard_detect (
    input  logic       mem_read_ex,
    input  logic       reg_we_ex,
    input  logic [4:0] reg_write_addr_ex,
    input  logic [4:0] rs_addr_id,
    input  logic [4:0] rt_addr_id,
    input  logic       uses_rs_id,
    input  logic       uses_rt_id,
    output logic       load_use
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = uses_rs_id && (rs_addr_id == reg_write_addr_ex);
    assign rt_hit = uses_rt_id && (rt_addr_id == reg_write_addr_ex);

    assign load_use = mem_read_ex && reg_we_ex && (reg_write_addr_ex != 5'd0)
                      && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control FSM: load-use stalls, two-cycle trap flush/redirect, EPC/cause
// capture and a saturating stall counter. Define PIPE_CTRL_STEP_EN for debug halt/step.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [31:0] TRAP_VECTOR = DefaultTrapVector,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             trap_req,
    input  logic             alu_overflow,
    input  logic             mem_read_ex,
    input  logic             reg_we_ex,
    input  logic [4:0]       reg_write_addr_ex,
    input  logic [4:0]       rs_addr_id,
    input  logic [4:0]       rt_addr_id,
    input  logic             uses_rs_id,
    input  logic             uses_rt_id,
    input  logic [31:0]      pc_id,
    input  logic [31:0]      pc_ex,
    input  logic             halt_req,
    input  logic             step_req,
    output logic             en_if,
    output logic             en_id,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [31:0]      epc,
    output logic [1:0]       cause,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] stall_count
);

    state_t           state_q;
    logic [31:0]      epc_q;
    logic [1:0]       cause_q;
    logic [CNT_W-1:0] stall_q;

    logic load_use;
    logic trap;
    logic run_cycle;

    hazard_detect u_hazard_detect (
        .mem_read_ex       (mem_read_ex),
        .reg_we_ex         (reg_we_ex),
        .reg_write_addr_ex (reg_write_addr_ex),
        .rs_addr_id        (rs_addr_id),
        .rt_addr_id        (rt_addr_id),
        .uses_rs_id        (uses_rs_id),
        .uses_rt_id        (uses_rt_id),
        .load_use          (load_use)
    );

    assign trap = trap_req || alu_overflow;

    // A step pulse while halted behaves exactly like one RUN cycle.
`ifdef PIPE_CTRL_STEP_EN
    assign run_cycle = (state_q == StRun) ||
                       ((state_q == StHalt) && halt_req && step_req);
`else
    assign run_cycle = (state_q == StRun);
    logic unused_dbg;
    assign unused_dbg = halt_req ^ step_req;
`endif

    always_comb begin
        en_if          = 1'b0;
        en_id          = 1'b0;
        flush_id       = 1'b0;
        flush_ex       = 1'b0;
        redirect_valid = 1'b0;
        if (rst) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
        end else if (en) begin
            if (run_cycle) begin
                if (!trap && load_use) begin
                    flush_id = 1'b1;
                end else begin
                    en_if = 1'b1;
                    en_id = 1'b1;
                end
            end else begin
                case (state_q)
                    StTrapFlush: begin
                        flush_id = 1'b1;
                        flush_ex = 1'b1;
                    end
                    StTrapRedirect: begin
                        redirect_valid = 1'b1;
                        en_if          = 1'b1;
                        flush_id       = 1'b1;
                    end
                    StHalt:  flush_id = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
            epc_q   <= 32'd0;
            cause_q <= CauseNone;
            stall_q <= '0;
        end else if (en) begin
            if (run_cycle) begin
                if (trap) begin
                    state_q <= StTrapFlush;
                    if (alu_overflow) begin
                        epc_q   <= pc_ex;
                        cause_q <= CauseOvf;
                    end else begin
                        epc_q   <= pc_id;
                        cause_q <= CauseExt;
                    end
                end else begin
                    if (load_use && (stall_q != {CNT_W{1'b1}})) begin
                        stall_q <= stall_q + CNT_W'(1);
                    end
`ifdef PIPE_CTRL_STEP_EN
                    state_q <= halt_req ? StHalt : StRun;
`else
                    state_q <= StRun;
`endif
                end
            end else begin
                case (state_q)
                    StTrapFlush:    state_q <= StTrapRedirect;
                    StTrapRedirect: state_q <= StRun;
                    StHalt:         if (!halt_req) state_q <= StRun;
                    default:        state_q <= StRun;
                endcase
            end
        end
    end

    assign redirect_pc = TRAP_VECTOR;
    assign epc         = epc_q;
    assign cause       = cause_q;
    assign state       = state_q;
    assign stall_count = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl (2-bit stall counter to reach saturation).
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        rst, en, trap_req, alu_overflow, mem_read_ex, reg_we_ex;
    logic [4:0]  reg_write_addr_ex, rs_addr_id, rt_addr_id;
    logic        uses_rs_id, uses_rt_id, halt_req, step_req;
    logic [31:0] pc_id, pc_ex;
    logic        en_if, en_id, flush_id, flush_ex, redirect_valid;
    logic [31:0] redirect_pc, epc;
    logic [1:0]  cause;
    logic [2:0]  state;
    logic [1:0]  stall_count;

    int n_cmp = 0;
    int n_err = 0;

    pipeline_ctrl #(
        .TRAP_VECTOR (32'd2000),
        .CNT_W       (2)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .en                (en),
        .trap_req          (trap_req),
        .alu_overflow      (alu_overflow),
        .mem_read_ex       (mem_read_ex),
        .reg_we_ex         (reg_we_ex),
        .reg_write_addr_ex (reg_write_addr_ex),
        .rs_addr_id        (rs_addr_id),
        .rt_addr_id        (rt_addr_id),
        .uses_rs_id        (uses_rs_id),
        .uses_rt_id        (uses_rt_id),
        .pc_id             (pc_id),
        .pc_ex             (pc_ex),
        .halt_req          (halt_req),
        .step_req          (step_req),
        .en_if             (en_if),
        .en_id             (en_id),
        .flush_id          (flush_id),
        .flush_ex          (flush_ex),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .epc               (epc),
        .cause             (cause),
        .state             (state),
        .stall_count       (stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Control outputs packed as {en_if, en_id, flush_id, flush_ex, redirect_valid}.
    task automatic chk_ctl(input string tag, input logic [4:0] exp);
        chk(tag, 32'({en_if, en_id, flush_id, flush_ex, redirect_valid}), 32'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        en = 1'b1; trap_req = 1'b0; alu_overflow = 1'b0;
        mem_read_ex = 1'b0; reg_we_ex = 1'b0; reg_write_addr_ex = 5'd0;
        rs_addr_id = 5'd0; rt_addr_id = 5'd0; uses_rs_id = 1'b0; uses_rt_id = 1'b0;
        pc_id = 32'h0; pc_ex = 32'h0; halt_req = 1'b0; step_req = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #2;
        chk_ctl("rst_outputs", 5'b00110);
        tick();
        tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_epc", epc, 32'd0);
        chk("rst_cause", 32'(cause), 32'd0);
        chk("rst_stall", 32'(stall_count), 32'd0);
        rst = 1'b0;
        #1;
        chk_ctl("run_idle", 5'b11000);
        chk("redirect_pc_idle", redirect_pc, 32'd2000);

        // lw $8 in EX, add reading $8 in ID
        mem_read_ex = 1'b1; reg_we_ex = 1'b1; reg_write_addr_ex = 5'd8;
        rs_addr_id = 5'd8; uses_rs_id = 1'b1;
        #1;
        chk_ctl("loaduse_rs", 5'b00100);
        tick();
        chk("stall_1", 32'(stall_count), 32'd1);
        mem_read_ex = 1'b0;
        #1;
        chk_ctl("after_stall", 5'b11000);

        // Load to $0 never stalls
        mem_read_ex = 1'b1; reg_write_addr_ex = 5'd0; rs_addr_id = 5'd0;
        #1;
        chk_ctl("load_r0", 5'b11000);
        tick();
        chk("stall_r0", 32'(stall_count), 32'd1);

        // rt match but rt unused: no stall
        reg_write_addr_ex = 5'd5; rt_addr_id = 5'd5; uses_rs_id = 1'b0; uses_rt_id = 1'b0;
        #1;
        chk_ctl("rt_unused", 5'b11000);
        uses_rt_id = 1'b1;
        #1;
        chk_ctl("loaduse_rt", 5'b00100);
        tick();
        tick();
        tick();
        chk("stall_sat", 32'(stall_count), 32'd3);
        idle();

        // Overflow trap from pc_ex
        alu_overflow = 1'b1; pc_ex = 32'h40; pc_id = 32'h3c;
        tick();
        idle();
        trap_req = 1'b1; pc_id = 32'h99;
        #1;
        chk("ovf_state_flush", 32'(state), 32'd1);
        chk_ctl("ovf_flush_ctl", 5'b00110);
        chk("ovf_epc", epc, 32'h40);
        chk("ovf_cause", 32'(cause), 32'd1);
        tick();
        trap_req = 1'b0;
        #1;
        chk("ovf_state_redir", 32'(state), 32'd2);
        chk_ctl("ovf_redir_ctl", 5'b10101);
        chk("ovf_redir_pc", redirect_pc, 32'd2000);
        chk("ovf_epc_hold", epc, 32'h40);
        chk("ovf_cause_hold", 32'(cause), 32'd1);
        tick();
        chk("ovf_back_run", 32'(state), 32'd0);
        chk_ctl("ovf_run_ctl", 5'b11000);

        // Both sources: overflow wins; repeat request in TRAP_FLUSH ignored
        trap_req = 1'b1; alu_overflow = 1'b1; pc_ex = 32'h80; pc_id = 32'h7c;
        tick();
        alu_overflow = 1'b0;
        chk("both_cause", 32'(cause), 32'd1);
        chk("both_epc", epc, 32'h80);
        tick();
        chk("both_ignored", 32'(state), 32'd2);
        chk("both_epc_hold", epc, 32'h80);
        trap_req = 1'b0;
        tick();
        chk("both_run", 32'(state), 32'd0);

        // External trap, then en=0 for 3 cycles inside TRAP_FLUSH
        trap_req = 1'b1; pc_id = 32'h100;
        tick();
        trap_req = 1'b0;
        chk("ext_cause", 32'(cause), 32'd2);
        chk("ext_epc", epc, 32'h100);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk_ctl("en0_ctl", 5'b00000);
            tick();
            chk("en0_state", 32'(state), 32'd1);
        end
        en = 1'b1;
        #1;
        chk_ctl("resume_flush", 5'b00110);
        tick();
        chk("resume_redir", 32'(state), 32'd2);
        tick();
        chk("resume_run", 32'(state), 32'd0);

        // en=0 during a load-use: no stall outputs
        en = 1'b0; mem_read_ex = 1'b1; reg_we_ex = 1'b1; reg_write_addr_ex = 5'd3;
        rs_addr_id = 5'd3; uses_rs_id = 1'b1;
        #1;
        chk_ctl("en0_loaduse", 5'b00000);
        idle();

        // Reset while in TRAP_REDIRECT abandons the trap
        alu_overflow = 1'b1; pc_ex = 32'h200;
        tick();
        alu_overflow = 1'b0;
        tick();
        chk("pre_rst_redir", 32'(state), 32'd2);
        rst = 1'b1;
        #1;
        chk_ctl("rst_in_redir", 5'b00110);
        tick();
        rst = 1'b0;
        chk("rst_redir_state", 32'(state), 32'd0);
        chk("rst_redir_epc", epc, 32'd0);
        #1;
        chk_ctl("post_rst_ctl", 5'b11000);
        tick();
        chk("post_rst_rv", 32'(redirect_valid), 32'd0);

`ifdef PIPE_CTRL_STEP_EN
        halt_req = 1'b1;
        tick();
        chk("halt_state", 32'(state), 32'd3);
        chk_ctl("halt_ctl", 5'b00100);
        tick();
        chk("halt_hold", 32'(state), 32'd3);
        step_req = 1'b1;
        #1;
        chk_ctl("step_ctl", 5'b11000);
        tick();
        step_req = 1'b0;
        chk("step_back_halt", 32'(state), 32'd3);
        chk_ctl("step_once", 5'b00100);
        halt_req = 1'b0;
        tick();
        chk("unhalt", 32'(state), 32'd0);
`else
        halt_req = 1'b1; step_req = 1'b1;
        #1;
        chk_ctl("halt_ignored_ctl", 5'b11000);
        tick();
        chk("halt_ignored", 32'(state), 32'd0);
        idle();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter TRAP_VECTOR, default 32'd2000, meaning the PC loaded on any trap.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the stall counter width.
REQ-003 SHALL have port clk  in  1  the single clock for all state.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port en  in  1  global pipeline enable.
REQ-006 SHALL have port trap_req  in  1  external trap request, level.
REQ-007 SHALL have port alu_overflow  in  1  EX-stage overflow.
REQ-008 SHALL have ports mem_read_ex, reg_we_ex  in  1 each  EX instruction is a load / writes a register.
REQ-009 SHALL have port reg_write_addr_ex  in  5  EX destination register.
REQ-010 SHALL have ports rs_addr_id, rt_addr_id  in  5 each  ID source registers.
REQ-011 SHALL have ports uses_rs_id, uses_rt_id  in  1 each  ID instruction reads rs / rt.
REQ-012 SHALL have ports pc_id, pc_ex  in  32 each  PCs of the ID and EX instructions.
REQ-013 SHALL have ports halt_req, step_req  in  1 each  debug halt level / single-step pulse.
REQ-014 SHALL have outputs en_if, en_id, flush_id, flush_ex, redirect_valid  out  1 each  meanings per Function.
REQ-015 SHALL have outputs redirect_pc  out  32; epc  out  32; cause  out  2; state  out  3; stall_count  out  CNT_W.

Function
REQ-016 SHALL flag load-use when mem_read_ex & reg_we_ex & reg_write_addr_ex!=0 & ((uses_rs_id & rs_addr_id==reg_write_addr_ex) | (uses_rt_id & rt_addr_id==reg_write_addr_ex)).
REQ-017 In RUN with en=1 and no trap: load-use gives en_if=0, en_id=0, flush_id=1 (bubble into ID/EX) in the same cycle; otherwise en_if=en_id=1 and flush_id=flush_ex=0.
REQ-018 SHALL have states RUN=0, TRAP_FLUSH=1, TRAP_REDIRECT=2, HALT=3, driven on the state output.
REQ-019 In RUN with en=1, trap_req|alu_overflow SHALL move to TRAP_FLUSH next cycle, taking priority over load-use.
- Same edge: epc<=pc_ex, cause<=2'b01 on overflow; else epc<=pc_id, cause<=2'b10. Overflow wins if both.
REQ-020 TRAP_FLUSH: en_if=0, en_id=0, flush_id=1, flush_ex=1; next state TRAP_REDIRECT.
REQ-021 TRAP_REDIRECT: redirect_valid=1, redirect_pc=TRAP_VECTOR, en_if=1, en_id=0, flush_id=1; next state RUN.
- Trap is exactly 2 cycles from detection to redirect.
REQ-022 trap_req/alu_overflow SHALL be ignored in TRAP_FLUSH and TRAP_REDIRECT; epc/cause hold.
REQ-023 redirect_pc SHALL equal TRAP_VECTOR at all times; only redirect_valid qualifies it.
REQ-024 stall_count SHALL increment by 1 each en=1 load-use stall cycle in RUN; saturates at all-ones, no wrap.
REQ-025 With en=0: state, epc, cause, stall_count hold; en_if=en_id=flush_id=flush_ex=redirect_valid=0.

Reset
REQ-026 With rst=1 at a clk edge: state<=RUN, epc<=0, cause<=0, stall_count<=0.
REQ-027 While rst=1: en_if=0, en_id=0, flush_id=1, flush_ex=1, redirect_valid=0.
REQ-028 rst mid-trap SHALL abandon the sequence; no redirect_valid after reset.

Configuration
REQ-029 Macro PIPE_CTRL_STEP_EN SHALL compile in debug halt/step.
- Defined: RUN with halt_req=1 and no trap goes to HALT.
- HALT: en_if=en_id=0, flush_id=1.
- A step_req cycle applies one RUN-cycle behaviour (including load-use and trap entry), then returns to HALT.
- halt_req=0 in HALT returns to RUN.
- Undefined: halt_req/step_req exist but are ignored; state never equals 3.

Structure
REQ-030 Package pipeline_ctrl_pkg SHALL hold the state encoding, cause codes (NONE=0, OVF=1, EXT=2) and the default TRAP_VECTOR constant.
REQ-031 Load-use compare SHALL be a combinational sub-module hazard_detect instantiated once; FSM, EPC and counter live in pipeline_ctrl.

Verification
REQ-032 The bench SHALL cover these scenarios:
- Load-use: EX lw to $8, ID add reads $8 -> one cycle en_if=0, flush_id=1; stall_count 0->1.
- Load to $0 with an ID read of $0 -> no stall.
- alu_overflow with pc_ex=0x40 -> next cycle TRAP_FLUSH with flush_ex=1, then redirect_valid=1 with redirect_pc=2000; epc=0x40, cause=1.
- trap_req and alu_overflow together -> cause=1; a second trap_req during TRAP_FLUSH is ignored.
- en=0 for 3 cycles in TRAP_FLUSH -> state held, outputs 0; sequence resumes when en=1.
- STEP_EN build: halt_req=1 -> HALT; one step_req -> exactly one cycle en_if=1; rst in TRAP_REDIRECT -> state=0, epc=0.
